clk_div_gen: RTL

Parametrised multi-channel clock generator running entirely in the `sys_clk` domain. It produces `NUM_CH` independently programmable divided clocks with matching single-cycle tick strobes, and a `locked_o` indication modelled on PLL lock behaviour. It replaces a fixed single-output clock test block. It sits next to the board oscillator input and feeds slow-clock consumers: LED blinkers, UART baud ticks and sampling enables.

---
 rtl/clk_div_gen_pkg.sv | 16 +
 rtl/clk_div_ch.sv | 100 ++++++++++
 rtl/clk_div_gen.sv | 85 ++++++++
 3 files changed

// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the clk_div_gen multi-channel clock generator.
// Optional start-phase support is enabled with the CLK_DIV_GEN_PHASE_EN macro.
package clk_div_gen_pkg;

  typedef enum logic {
    LOCKING = 1'b0,
    RUN     = 1'b1
  } lock_state_e;

  localparam int DIV_MIN = 2;

  function automatic logic [31:0] half_ceil(input logic [31:0] d);
    return (d >> 1) + {31'd0, d[0]};
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: latched divide/phase, wrap counter, registered clk/tick.
// With CLK_DIV_GEN_PHASE_EN defined the counter starts at a programmable offset.
module clk_div_ch #(
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic [DIV_W-1:0] i_div,
`ifdef CLK_DIV_GEN_PHASE_EN
  input  logic [DIV_W-1:0] i_phase,
`endif
  output logic             o_clk,
  output logic             o_tick
);
  import clk_div_gen_pkg::*;

  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_MIN);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_running;
  logic             r_enPrev;
  logic             r_clk;
  logic             r_tick;

  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_start;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_cntNext;
  logic             w_restart;

  assign w_last  = r_div - DIV_W'(1);
  assign w_half  = DIV_W'(half_ceil(32'(r_div)));

`ifdef CLK_DIV_GEN_PHASE_EN
  logic [DIV_W-1:0] r_phase;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (i_ld) begin
      r_phase <= i_phase;
    end
  end

  // Phase beyond the period is clamped to the last count.
  assign w_start = (r_phase > w_last) ? w_last : r_phase;
`else
  assign w_start = '0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_RESET;
    end else if (i_ld) begin
      r_div <= (i_div < DIV_RESET) ? DIV_RESET : i_div;
    end
  end

  // Restart on RUN entry or on a rising enable so the first output cycle is at the start value.
  assign w_restart = (i_run && !r_running) || (i_en && !r_enPrev);

  always_comb begin
    w_cntNext = '0;
    if (w_restart) begin
      w_cntNext = w_start;
    end else if (r_cnt != w_last) begin
      w_cntNext = r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_enPrev  <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_running <= i_run;
      r_enPrev  <= i_en;
      if (!i_run || !i_en) begin
        r_cnt  <= w_start;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= w_cntNext;
        r_clk  <= (w_cntNext < w_half);
        r_tick <= (w_cntNext == '0);
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock generator with PLL-style lock indication.
// Define CLK_DIV_GEN_PHASE_EN to add the phase_i port and per-channel start offsets.
module clk_div_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
`ifdef CLK_DIV_GEN_PHASE_EN
  input  logic [NUM_CH*DIV_W-1:0] phase_i,
`endif
  input  logic                    ld_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic                    locked_o
);
  import clk_div_gen_pkg::*;

  localparam int               LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  lock_state_e    r_state;
  logic [LCW-1:0] r_lockCnt;
  logic           r_locked;

  logic           w_lockDone;
  logic           w_runNext;

  assign w_lockDone = (r_state == LOCKING) && (r_lockCnt == LOCK_LAST);
  // Channels see the state being entered, so they produce output on the lock edge itself.
  assign w_runNext  = !ld_i && ((r_state == RUN) || w_lockDone);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOCKING;
      r_lockCnt <= '0;
      r_locked  <= 1'b0;
    end else if (ld_i) begin
      r_state   <= LOCKING;
      r_lockCnt <= '0;
      r_locked  <= 1'b0;
    end else begin
      case (r_state)
        LOCKING: begin
          if (r_lockCnt == LOCK_LAST) begin
            r_state  <= RUN;
            r_locked <= 1'b1;
          end else begin
            r_lockCnt <= r_lockCnt + LCW'(1);
          end
        end
        RUN: begin
          r_locked <= 1'b1;
        end
        default: begin
          r_state <= LOCKING;
        end
      endcase
    end
  end

  assign locked_o = r_locked;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .i_run   (w_runNext),
      .i_en    (ch_en_i[g]),
      .i_ld    (ld_i),
      .i_div   (div_i[g*DIV_W +: DIV_W]),
`ifdef CLK_DIV_GEN_PHASE_EN
      .i_phase (phase_i[g*DIV_W +: DIV_W]),
`endif
      .o_clk   (clk_o[g]),
      .o_tick  (tick_o[g])
    );
  end

endmodule
